regfile_wr_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file, i.e. the Addr/WrEn pair feeding DECODER_5_32 and the write-data bus.
- After reset or a Clear request, sweeps all 32 registers and writes zero to each.
- Afterwards, arbitrates round-robin between two writeback requesters: A (ALU result) and B (memory load).
- Uses a valid/ready handshake and issues at most one registered write per cycle.

---
 rtl/regfile_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Owns the single write port of the register file. After reset or a Clear
//   request it sweeps every register and writes zero. It then arbitrates
//   round-robin between two writeback requesters, A (ALU result) and
//   B (memory load), using a valid/ready handshake. It issues at most one
//   registered write per cycle.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Clear     in   synchronous request to re-run the zero sweep (ignored in INIT)
//   A_Valid   in   requester A has a write pending
//   A_Addr    in   requester A destination register
//   A_Data    in   requester A write data
//   A_Ready   out  port accepts A this cycle
//   B_Valid   in   requester B has a write pending
//   B_Addr    in   requester B destination register
//   B_Data    in   requester B write data
//   B_Ready   out  port accepts B this cycle
//   Addr      out  register-file write address (to the decoder)
//   WrEn      out  register-file write enable
//   DataOut   out  register-file write data
//   InitDone  out  high once the zero sweep has completed
module regfile_wr_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Clear,
   input  logic              A_Valid,
   input  logic [ADDR_W-1:0] A_Addr,
   input  logic [DATA_W-1:0] A_Data,
   output logic              A_Ready,
   input  logic              B_Valid,
   input  logic [ADDR_W-1:0] B_Addr,
   input  logic [DATA_W-1:0] B_Data,
   output logic              B_Ready,
   output logic [ADDR_W-1:0] Addr,
   output logic              WrEn,
   output logic [DATA_W-1:0] DataOut,
   output logic              InitDone
);

   typedef enum logic [0:0] {StInit, StArb} stateT;

   // Round-robin pointer: names the requester that wins the next contested cycle.
   localparam logic PtrA = 1'b0;
   localparam logic PtrB = 1'b1;

   // Sweep counter is one bit wider than the address so it can reach NUM_REGS,
   // which marks the extra edge that hands over to arbitration.
   localparam logic [ADDR_W:0] SweepEnd = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);

   stateT             stateQ, stateD;
   logic [ADDR_W:0]   sweepCntQ, sweepCntD;
   logic              ptrQ, ptrD;
   logic [ADDR_W-1:0] addrQ, addrD;
   logic [DATA_W-1:0] dataQ, dataD;
   logic              wrEnQ, wrEnD;
   logic              initDoneQ, initDoneD;

   logic aReady, bReady;
   logic grantA, grantB;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ    <= StInit;
         sweepCntQ <= '0;
         ptrQ      <= PtrA;
         addrQ     <= '0;
         dataQ     <= '0;
         wrEnQ     <= 1'b0;
         initDoneQ <= 1'b0;
      end else begin
         stateQ    <= stateD;
         sweepCntQ <= sweepCntD;
         ptrQ      <= ptrD;
         addrQ     <= addrD;
         dataQ     <= dataD;
         wrEnQ     <= wrEnD;
         initDoneQ <= initDoneD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      sweepCntD = sweepCntQ;
      ptrD      = ptrQ;
      addrD     = addrQ;
      dataD     = dataQ;
      wrEnD     = 1'b0;
      initDoneD = initDoneQ;
      aReady    = 1'b0;
      bReady    = 1'b0;
      grantA    = 1'b0;
      grantB    = 1'b0;

      case (stateQ)
         StInit: begin
            if (sweepCntQ == SweepEnd) begin
               stateD    = StArb;
               initDoneD = 1'b1;
               sweepCntD = '0;
            end else begin
               addrD     = sweepCntQ[ADDR_W-1:0];
               dataD     = '0;
               wrEnD     = 1'b1;
               sweepCntD = sweepCntQ + CntOne;
            end
         end

         StArb: begin
            // Readiness looks only at the other requester, so a requester may
            // evaluate Ready before deciding to raise Valid.
            aReady = !Clear && (!B_Valid || (ptrQ == PtrA));
            bReady = !Clear && (!A_Valid || (ptrQ == PtrB));
            grantA = A_Valid && aReady;
            grantB = B_Valid && bReady;

            if (Clear) begin
               stateD    = StInit;
               initDoneD = 1'b0;
               sweepCntD = '0;
            end else if (grantA) begin
               addrD = A_Addr;
               dataD = A_Data;
               wrEnD = (A_Addr != '0);
            end else if (grantB) begin
               addrD = B_Addr;
               dataD = B_Data;
               wrEnD = (B_Addr != '0);
            end

            // Only a contested grant moves the pointer, to the loser.
            if (A_Valid && B_Valid && (grantA || grantB)) begin
               ptrD = grantA ? PtrB : PtrA;
            end
         end

         default: begin
            stateD = StInit;
         end
      endcase
   end

   assign A_Ready  = aReady;
   assign B_Ready  = bReady;
   assign Addr     = addrQ;
   assign WrEn     = wrEnQ;
   assign DataOut  = dataQ;
   assign InitDone = initDoneQ;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Clear;
   logic        A_Valid, B_Valid;
   logic [4:0]  A_Addr, B_Addr, Addr;
   logic [31:0] A_Data, B_Data, DataOut;
   logic        A_Ready, B_Ready, WrEn, InitDone;

   int errors = 0;
   int checks = 0;

   // Register file as seen through the write port, and as the model expects it.
   logic [31:0] dutRf   [32];
   logic [31:0] modelRf [32];

   // Model state: whose turn a tie goes to (0 = A, 1 = B), and the write-port
   // address/data expected to be held when nothing is transferred.
   int          turn;
   logic [4:0]  expAddr;
   logic [31:0] expData;

   regfile_wr_arbiter #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (32)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear    (Clear),
      .A_Valid  (A_Valid),
      .A_Addr   (A_Addr),
      .A_Data   (A_Data),
      .A_Ready  (A_Ready),
      .B_Valid  (B_Valid),
      .B_Addr   (B_Addr),
      .B_Data   (B_Data),
      .B_Ready  (B_Ready),
      .Addr     (Addr),
      .WrEn     (WrEn),
      .DataOut  (DataOut),
      .InitDone (InitDone)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later; record any write.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (WrEn === 1'b1) dutRf[Addr] = DataOut;
   endtask

   // Full zero sweep starting from the INIT state, then the hand-over edge.
   task automatic sweepCheck(input string tag);
      for (int i = 0; i < 32; i++) begin
         #1;
         chk({tag, ".aRdy"}, {31'b0, A_Ready}, 32'd0);
         chk({tag, ".bRdy"}, {31'b0, B_Ready}, 32'd0);
         tick();
         chk({tag, ".addr"}, {27'b0, Addr}, i);
         chk({tag, ".wrEn"}, {31'b0, WrEn}, 32'd1);
         chk({tag, ".data"}, DataOut, 32'd0);
         chk({tag, ".init"}, {31'b0, InitDone}, 32'd0);
      end
      tick();
      chk({tag, ".endWr"}, {31'b0, WrEn}, 32'd0);
      chk({tag, ".endInit"}, {31'b0, InitDone}, 32'd1);
      for (int r = 0; r < 32; r++) modelRf[r] = '0;
      expAddr = 5'd31;
      expData = '0;
   endtask

   // One arbitration cycle against the model, with inputs already driven.
   task automatic arbCycle(input string tag, output logic gA, output logic gB);
      logic expA, expB, expWr;
      #1;
      expA = !Clear && (!B_Valid || turn == 0);
      expB = !Clear && (!A_Valid || turn == 1);
      chk({tag, ".aRdy"}, {31'b0, A_Ready}, {31'b0, expA});
      chk({tag, ".bRdy"}, {31'b0, B_Ready}, {31'b0, expB});
      gA = A_Valid && expA;
      gB = B_Valid && expB;
      expWr = 1'b0;
      if (A_Valid && B_Valid && (gA || gB)) turn = gA ? 1 : 0;
      if (gA) begin
         expAddr = A_Addr;
         expData = A_Data;
         expWr   = (A_Addr != 0);
      end else if (gB) begin
         expAddr = B_Addr;
         expData = B_Data;
         expWr   = (B_Addr != 0);
      end
      if (expWr) modelRf[expAddr] = expData;
      tick();
      chk({tag, ".wrEn"}, {31'b0, WrEn}, {31'b0, expWr});
      chk({tag, ".addr"}, {27'b0, Addr}, {27'b0, expAddr});
      chk({tag, ".data"}, DataOut, expData);
      chk({tag, ".init"}, {31'b0, InitDone}, 32'd1);
   endtask

   initial begin
      logic gA, gB, aPend, bPend;
      Reset   = 1'b1;
      Clear   = 1'b0;
      A_Valid = 1'b0;
      B_Valid = 1'b0;
      A_Addr  = '0;
      B_Addr  = '0;
      A_Data  = '0;
      B_Data  = '0;
      turn    = 0;
      expAddr = '0;
      expData = '0;
      for (int r = 0; r < 32; r++) begin
         dutRf[r]   = '0;
         modelRf[r] = '0;
      end

      // Reset state, with A already requesting.
      tick();
      tick();
      A_Valid = 1'b1;
      A_Addr  = 5'd5;
      A_Data  = 32'hDEADBEEF;
      #1;
      chk("rst.wrEn", {31'b0, WrEn}, 32'd0);
      chk("rst.addr", {27'b0, Addr}, 32'd0);
      chk("rst.data", DataOut, 32'd0);
      chk("rst.init", {31'b0, InitDone}, 32'd0);
      chk("rst.aRdy", {31'b0, A_Ready}, 32'd0);
      Reset = 1'b0;

      // Sweep ignores the pending A request.
      sweepCheck("init");

      // A alone, then an idle cycle holding Addr/DataOut.
      arbCycle("aOnly", gA, gB);
      A_Valid = 1'b0;
      arbCycle("aIdle", gA, gB);

      // Both continuously valid: A,B,A,B with fresh data after each grant.
      A_Valid = 1'b1;
      B_Valid = 1'b1;
      A_Addr  = 5'd3;
      B_Addr  = 5'd7;
      A_Data  = 32'h11;
      B_Data  = 32'h22;
      for (int k = 0; k < 4; k++) begin
         arbCycle("alt", gA, gB);
         chk("alt.order", {27'b0, Addr}, (k % 2 == 0) ? 32'd3 : 32'd7);
         if (gA) A_Data = A_Data + 32'h100;
         if (gB) B_Data = B_Data + 32'h100;
      end
      A_Valid = 1'b0;
      B_Valid = 1'b0;

      // Write to register 0 is consumed but not asserted.
      A_Valid = 1'b1;
      A_Addr  = 5'd0;
      A_Data  = 32'hFFFFFFFF;
      arbCycle("zero", gA, gB);
      chk("zero.wrEn", {31'b0, WrEn}, 32'd0);
      A_Valid = 1'b0;

      // Random traffic obeying hold-until-ready.
      aPend = 1'b0;
      bPend = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!aPend) begin
            A_Valid = ($urandom_range(0, 2) != 0);
            A_Addr  = 5'($urandom_range(0, 31));
            A_Data  = $urandom;
         end
         if (!bPend) begin
            B_Valid = ($urandom_range(0, 2) != 0);
            B_Addr  = 5'($urandom_range(0, 31));
            B_Data  = $urandom;
         end
         arbCycle("rand", gA, gB);
         aPend = A_Valid && !gA;
         bPend = B_Valid && !gB;
      end
      for (int r = 0; r < 32; r++) chk("rf", dutRf[r], modelRf[r]);

      // Clear with B waiting: B blocked until the sweep completes.
      A_Valid = 1'b0;
      B_Valid = 1'b1;
      B_Addr  = 5'd9;
      B_Data  = 32'hCAFE;
      Clear   = 1'b1;
      #1;
      chk("clr.bRdy", {31'b0, B_Ready}, 32'd0);
      tick();
      chk("clr.init", {31'b0, InitDone}, 32'd0);
      chk("clr.wrEn", {31'b0, WrEn}, 32'd0);
      Clear = 1'b0;
      sweepCheck("clrSweep");
      arbCycle("postClr", gA, gB);
      chk("postClr.grant", {27'b0, Addr}, 32'd9);
      B_Valid = 1'b0;
      chk("postClr.rf9", dutRf[9], 32'hCAFE);

      // Reset mid-sweep acts without a clock edge, then the sweep restarts.
      Reset = 1'b1;
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      chk("mid.addr", {27'b0, Addr}, 32'd12);
      chk("mid.wrEn", {31'b0, WrEn}, 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      chk("async.wrEn", {31'b0, WrEn}, 32'd0);
      chk("async.addr", {27'b0, Addr}, 32'd0);
      chk("async.init", {31'b0, InitDone}, 32'd0);
      Reset = 1'b0;
      turn  = 0;
      sweepCheck("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
